video_led_judge_gen: RTL and testbench
======================================

// Module: video_led_judge_gen
// PURPOSE
//  Parametrised LED-overlay hit judge for the font/NTSC video path: per pixel it decides whether (HCTRs_i,VCTRs_i)
//  lies on one of C_LED_N programmable LED sprites and outputs hit / colour-enable / colour-phase.
//  Replaces the fixed-table judge: a run-time location/shape/colour table, double-buffered and committed at frame
//  start, four shapes, per-LED blink, and a registered 2-stage pipeline. Sits between the H/V counters and the video mixer.
// PARAMETERS
//  C_LED_N    18  number of LED sprites (1..64)
//  C_HW       9   horizontal counter / X width
//  C_VW       8   vertical counter / Y width
//  C_RAD      7   sprite radius R in pixels (|d| <= R)
//  C_PHW      3   colour-phase width
//  C_BLINK_W  5   frame-counter width; blink period = 2^C_BLINK_W frames
//  (derived) C_IW = clog2(C_LED_N+1); C_DW = C_HW+C_VW+4+C_PHW (entry width, 24 at defaults)
// PORTS
//  CK_i             in   1       clock (only clock)
//  RST_i            in   1       synchronous, active-high reset
//  CK_EE_i          in   1       pixel enable; pipeline, FRAME_i and blink counter advance only when 1
//  FRAME_i          in   1       frame-start pulse (sampled when CK_EE_i=1): commit shadow table, step blink counter
//  HCTRs_i          in   C_HW    pixel X
//  VCTRs_i          in   C_VW    pixel Y
//  LEDs_ON_i        in   C_LED_N live on/off per LED
//  WR_i             in   1       table write strobe (ignores CK_EE_i)
//  WR_ADRs_i        in   C_IW    LED index to write
//  WR_DATs_i        in   C_DW    {PH[C_PHW], COLOR_ON, BLINK, SHAPE[2], Y[C_VW], X[C_HW]} (X at LSB)
//  LED_HIT_o        out  1       pixel is on a lit LED
//  LED_COLOR_ON_o   out  1       winning LED uses colour
//  LED_COLOR_PHs_o  out  C_PHW   colour phase of winning LED
//  LED_IDXs_o       out  C_IW    winning LED index, all-ones when no geometric hit
// BEHAVIOUR
//  Reset: all outputs 0 except LED_IDXs_o=all-ones; shadow+active entries = 0 with SHAPE=3 (off); blink ctr=0.
//  Table: shadow written on any CK_i cycle with WR_i=1 and WR_ADRs_i<C_LED_N; addresses >=C_LED_N ignored.
//   Active table <= shadow on CK_EE_i&FRAME_i; a write in the same cycle is included in the commit.
//   The judge reads only the active table, so a frame never shows a partial update.
//  Geometry (exact, unsigned extended to 32b): dx=|H-X|, dy=|V-Y| (true abs, no one's-complement shortcut).
//   SHAPE 0 square: dx<=R & dy<=R. 1 diamond: dx+dy<=R. 2 hollow square: max(dx,dy) in {R-1,R}. 3 disabled.
//  Blink: ctr += 1 (wrapping) on CK_EE_i&FRAME_i; entry with BLINK=1 is treated as unlit while ctr MSB=1.
//  Priority: lowest index with geometric hit wins (lit or not); a higher LED never shows through a lower one.
//  Pipeline (each stage advances only when CK_EE_i=1; holds otherwise):
//   S1: per-LED hit vector + priority encode -> registered index (all-ones if none).
//   S2: HIT = LEDs_ON_i[idx] & ~blinkoff[idx] & hit; COLOR_ON = entry.COLOR_ON & hit; PH = hit ? entry.PH : 0.
//   Latency exactly 2 enabled cycles from HCTRs/VCTRs to outputs; S2 uses LEDs_ON_i and table at S2 time.
//  No hit: LED_HIT_o=0, LED_COLOR_ON_o=0, LED_COLOR_PHs_o=0, LED_IDXs_o=all-ones.
//  Near counter edges (X<R or H wrap) no wrap-around: distances are true absolute differences.
//  RST_i mid-frame: next cycle all state at reset values regardless of CK_EE_i; pipeline contents discarded.
// TESTING
//  T1 reset: RST_i=1 2 cycles -> LED_IDXs_o=all-ones, other outputs 0; any H/V for 3 frames -> no hit (all shapes off).
//  T2 write LED0 X=16,Y=16,SHAPE=0,PH=5,CO=1 then FRAME_i; LEDs_ON_i[0]=1; H=23,V=9 -> 2 cycles later HIT=1,PH=5,IDX=0; H=24 -> HIT=0.
//  T3 diamond at (32,32),R=7: (36,35) hit, (36,36) miss; hollow: (39,32) and (38,32) hit, (37,32) miss.
//  T4 write LED1 without FRAME_i -> no hit at its location; after FRAME_i pulse -> hit; write+FRAME same cycle -> hit next frame.
//  T5 LED0 and LED3 overlap, LEDs_ON_i[0]=0 -> IDX=0, HIT=0 (LED3 masked); BLINK=1: HIT=1 frames 0-15, 0 frames 16-31, back at 32.
//  T6 toggle CK_EE_i 1-of-4 -> outputs change only on enabled cycles, latency 2 enabled cycles; WR_ADRs_i=C_LED_N -> no table change.

Source files
------------

// File: rtl/video_led_judge_gen_if.sv
// Pixel stream, LED table write port and judge result of the LED-overlay hit judge.
// The master drives pixels/table writes; the slave (the judge) returns hit/colour results.
interface video_led_judge_gen_if #(
    parameter int C_LED_N = 18,
    parameter int C_HW    = 9,
    parameter int C_VW    = 8,
    parameter int C_PHW   = 3
);
    localparam int C_IW = $clog2(C_LED_N + 1);
    localparam int C_DW = C_HW + C_VW + 4 + C_PHW;

    logic               CK_EE_i;
    logic               FRAME_i;
    logic [C_HW-1:0]    HCTRs_i;
    logic [C_VW-1:0]    VCTRs_i;
    logic [C_LED_N-1:0] LEDs_ON_i;
    logic               WR_i;
    logic [C_IW-1:0]    WR_ADRs_i;
    logic [C_DW-1:0]    WR_DATs_i;
    logic               LED_HIT_o;
    logic               LED_COLOR_ON_o;
    logic [C_PHW-1:0]   LED_COLOR_PHs_o;
    logic [C_IW-1:0]    LED_IDXs_o;

    modport master (
        output CK_EE_i, FRAME_i, HCTRs_i, VCTRs_i, LEDs_ON_i, WR_i, WR_ADRs_i, WR_DATs_i,
        input  LED_HIT_o, LED_COLOR_ON_o, LED_COLOR_PHs_o, LED_IDXs_o
    );

    modport slave (
        input  CK_EE_i, FRAME_i, HCTRs_i, VCTRs_i, LEDs_ON_i, WR_i, WR_ADRs_i, WR_DATs_i,
        output LED_HIT_o, LED_COLOR_ON_o, LED_COLOR_PHs_o, LED_IDXs_o
    );
endinterface

// File: rtl/video_led_judge_gen.sv
// LED-overlay hit judge: double-buffered sprite table, four shapes, per-LED blink,
// and a 2-stage pixel-enabled pipeline from H/V counters to hit/colour outputs.
module video_led_judge_gen #(
    parameter int C_LED_N   = 18,
    parameter int C_HW      = 9,
    parameter int C_VW      = 8,
    parameter int C_RAD     = 7,
    parameter int C_PHW     = 3,
    parameter int C_BLINK_W = 5
) (
    input  logic                  CK_i,
    input  logic                  RST_i,
    video_led_judge_gen_if.slave  bus
);
    localparam int C_IW = $clog2(C_LED_N + 1);

    typedef enum logic [1:0] {
        SHAPE_SQUARE  = 2'd0,
        SHAPE_DIAMOND = 2'd1,
        SHAPE_HOLLOW  = 2'd2,
        SHAPE_OFF     = 2'd3
    } shape_e;

    typedef struct packed {
        logic [C_PHW-1:0] ph;
        logic             color_on;
        logic             blink;
        shape_e           shape;
        logic [C_VW-1:0]  y;
        logic [C_HW-1:0]  x;
    } entry_t;

    localparam entry_t C_ENTRY_RST = '{ph: '0, color_on: 1'b0, blink: 1'b0,
                                       shape: SHAPE_OFF, y: '0, x: '0};

    // Distances are taken in 32 bits so sprites near the counter edges never wrap around.
    function automatic logic f_geo_hit(entry_t e, logic [C_HW-1:0] h, logic [C_VW-1:0] v);
        logic [31:0] h32, v32, x32, y32, dx, dy, mx, rad;
        logic        hit;
        h32 = 32'(h);
        v32 = 32'(v);
        x32 = 32'(e.x);
        y32 = 32'(e.y);
        rad = 32'(C_RAD);
        dx  = (h32 >= x32) ? (h32 - x32) : (x32 - h32);
        dy  = (v32 >= y32) ? (v32 - y32) : (y32 - v32);
        mx  = (dx > dy) ? dx : dy;
        case (e.shape)
            SHAPE_SQUARE:  hit = (dx <= rad) && (dy <= rad);
            SHAPE_DIAMOND: hit = (dx + dy) <= rad;
            SHAPE_HOLLOW:  hit = (mx == rad) || (mx == rad - 32'd1);
            default:       hit = 1'b0;
        endcase
        return hit;
    endfunction

    entry_t               r_shadow [C_LED_N];
    entry_t               r_active [C_LED_N];
    logic [C_BLINK_W-1:0] r_blink_ctr;
    logic [C_IW-1:0]      r_s1_idx;
    logic                 r_s1_hit;
    logic                 r_hit;
    logic                 r_color_on;
    logic [C_PHW-1:0]     r_ph;
    logic [C_IW-1:0]      r_idx;

    entry_t               w_shadow_nxt [C_LED_N];
    logic                 w_commit;
    logic [C_LED_N-1:0]   w_geo_hit;
    logic [C_IW-1:0]      w_s1_idx;
    logic                 w_s1_hit;
    entry_t               w_sel;
    logic                 w_on;
    logic                 w_blink_off;

    assign w_commit = bus.CK_EE_i & bus.FRAME_i;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_shadow_nxt = r_shadow;
        for (int i = 0; i < C_LED_N; i++) begin
            if (bus.WR_i && (bus.WR_ADRs_i == C_IW'(i)))
                w_shadow_nxt[i] = entry_t'(bus.WR_DATs_i);
        end
    end

    // Lowest index with a geometric hit wins, whether or not it is lit.
    always_comb begin
        w_geo_hit = '0;
        w_s1_idx  = '1;
        w_s1_hit  = 1'b0;
        for (int i = 0; i < C_LED_N; i++)
            w_geo_hit[i] = f_geo_hit(r_active[i], bus.HCTRs_i, bus.VCTRs_i);
        for (int i = C_LED_N - 1; i >= 0; i--) begin
            if (w_geo_hit[i]) begin
                w_s1_idx = C_IW'(i);
                w_s1_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel = '0;
        w_on  = 1'b0;
        for (int i = 0; i < C_LED_N; i++) begin
            if (r_s1_hit && (r_s1_idx == C_IW'(i))) begin
                w_sel = r_active[i];
                w_on  = bus.LEDs_ON_i[i];
            end
        end
        w_blink_off = w_sel.blink & r_blink_ctr[C_BLINK_W-1];
    end

    // NOTE: sequential state uses non-blocking assignments only; the table is a small
    // register file and is reset explicitly so every sprite starts disabled.
    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            for (int i = 0; i < C_LED_N; i++) begin
                r_shadow[i] <= C_ENTRY_RST;
                r_active[i] <= C_ENTRY_RST;
            end
            r_blink_ctr <= '0;
            r_s1_idx    <= '1;
            r_s1_hit    <= 1'b0;
            r_hit       <= 1'b0;
            r_color_on  <= 1'b0;
            r_ph        <= '0;
            r_idx       <= '1;
        end else begin
            r_shadow <= w_shadow_nxt;
            if (w_commit) begin
                r_active    <= w_shadow_nxt;
                r_blink_ctr <= r_blink_ctr + C_BLINK_W'(1);
            end
            if (bus.CK_EE_i) begin
                r_s1_idx   <= w_s1_idx;
                r_s1_hit   <= w_s1_hit;
                r_hit      <= r_s1_hit & w_on & ~w_blink_off;
                r_color_on <= r_s1_hit & w_sel.color_on;
                r_ph       <= w_sel.ph;
                r_idx      <= r_s1_idx;
            end
        end
    end

    assign bus.LED_HIT_o       = r_hit;
    assign bus.LED_COLOR_ON_o  = r_color_on;
    assign bus.LED_COLOR_PHs_o = r_ph;
    assign bus.LED_IDXs_o      = r_idx;
endmodule

// File: tb/tb_video_led_judge_gen.sv
// Directed bench for video_led_judge_gen: shapes, double buffering, priority, blink,
// pixel-enable gating and reset, with hand-computed {hit,color_on,ph,idx} tuples.
module tb_video_led_judge_gen;
    localparam int N   = 18;
    localparam int HW  = 9;
    localparam int VW  = 8;
    localparam int PHW = 3;
    localparam int IW  = 5;
    localparam int DW  = 24;
    localparam logic [9:0] NONE = 10'h01f;

    typedef struct {
        int         h;
        int         v;
        logic [9:0] exp;
    } vec_t;

    typedef struct {
        bit         ee;
        int         h;
        int         v;
        logic [9:0] exp;
    } step_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   frame_cnt = 0;

    always #5 clk = ~clk;

    video_led_judge_gen_if bus ();

    video_led_judge_gen dut (
        .CK_i  (clk),
        .RST_i (rst),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] mk(int x, int y, int shape, bit blink, bit co, int ph);
        return {PHW'(ph), co, blink, 2'(shape), VW'(y), HW'(x)};
    endfunction

    function automatic logic [9:0] e(bit hit, bit co, int ph, int idx);
        return {hit, co, PHW'(ph), IW'(idx)};
    endfunction

    function automatic logic [9:0] obs();
        return {bus.LED_HIT_o, bus.LED_COLOR_ON_o, bus.LED_COLOR_PHs_o, bus.LED_IDXs_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        frame_cnt = 0;
    endtask

    task automatic pulse_frame();
        bus.FRAME_i = 1'b1;
        tick();
        if (bus.CK_EE_i) frame_cnt++;
        bus.FRAME_i = 1'b0;
    endtask

    task automatic write_entry(input int adr, input logic [DW-1:0] d, input bit with_frame);
        bus.WR_i      = 1'b1;
        bus.WR_ADRs_i = IW'(adr);
        bus.WR_DATs_i = d;
        bus.FRAME_i   = with_frame;
        tick();
        if (with_frame && bus.CK_EE_i) frame_cnt++;
        bus.WR_i    = 1'b0;
        bus.FRAME_i = 1'b0;
    endtask

    task automatic show(input int h, input int v);
        bus.HCTRs_i = HW'(h);
        bus.VCTRs_i = VW'(v);
        tick();
        tick();
    endtask

    task automatic test_reset();
        vec_t vs [3];
        bus.CK_EE_i = 1'b0;
        do_reset();
        n_checks++;
        if (obs() !== NONE) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", obs(), NONE);
        end
        bus.CK_EE_i   = 1'b1;
        bus.LEDs_ON_i = '1;
        vs = '{'{0, 0, NONE}, '{16, 16, NONE}, '{300, 200, NONE}};
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 3; k++) begin
                show(vs[k].h, vs[k].v);
                n_checks++;
                if (obs() !== vs[k].exp) begin
                    n_fail++;
                    $display("FAIL reset_nohit f%0d (%0d,%0d): got %h want %h",
                             f, vs[k].h, vs[k].v, obs(), vs[k].exp);
                end
            end
            pulse_frame();
        end
    endtask

    task automatic test_square();
        vec_t vs [4];
        write_entry(0, mk(16, 16, 0, 0, 1, 5), 1'b0);
        write_entry(2, mk(2, 2, 0, 0, 0, 1), 1'b0);
        pulse_frame();
        show(23, 9);
        n_checks++;
        if (obs() !== e(1, 1, 5, 0)) begin
            n_fail++;
            $display("FAIL square_corner: got %h want %h", obs(), e(1, 1, 5, 0));
        end
        // One enabled edge after moving off the sprite the old result must still show.
        bus.HCTRs_i = HW'(24);
        tick();
        n_checks++;
        if (obs() !== e(1, 1, 5, 0)) begin
            n_fail++;
            $display("FAIL square_latency1: got %h want %h", obs(), e(1, 1, 5, 0));
        end
        tick();
        n_checks++;
        if (obs() !== NONE) begin
            n_fail++;
            $display("FAIL square_outside: got %h want %h", obs(), NONE);
        end
        vs = '{'{0, 0, e(1, 0, 1, 2)}, '{511, 0, NONE}, '{0, 9, e(1, 0, 1, 2)}, '{0, 255, NONE}};
        for (int k = 0; k < 4; k++) begin
            show(vs[k].h, vs[k].v);
            n_checks++;
            if (obs() !== vs[k].exp) begin
                n_fail++;
                $display("FAIL edge (%0d,%0d): got %h want %h", vs[k].h, vs[k].v, obs(), vs[k].exp);
            end
        end
    endtask

    task automatic test_shapes();
        vec_t vd [4];
        vec_t vh [6];
        write_entry(1, mk(32, 32, 1, 0, 0, 3), 1'b1);
        vd = '{'{36, 35, e(1, 0, 3, 1)}, '{36, 36, NONE}, '{25, 32, e(1, 0, 3, 1)},
               '{32, 25, e(1, 0, 3, 1)}};
        for (int k = 0; k < 4; k++) begin
            show(vd[k].h, vd[k].v);
            n_checks++;
            if (obs() !== vd[k].exp) begin
                n_fail++;
                $display("FAIL diamond (%0d,%0d): got %h want %h", vd[k].h, vd[k].v, obs(), vd[k].exp);
            end
        end
        write_entry(1, mk(32, 32, 2, 0, 1, 6), 1'b1);
        vh = '{'{39, 32, e(1, 1, 6, 1)}, '{38, 32, e(1, 1, 6, 1)}, '{37, 32, NONE},
               '{32, 32, NONE}, '{25, 26, e(1, 1, 6, 1)}, '{40, 32, NONE}};
        for (int k = 0; k < 6; k++) begin
            show(vh[k].h, vh[k].v);
            n_checks++;
            if (obs() !== vh[k].exp) begin
                n_fail++;
                $display("FAIL hollow (%0d,%0d): got %h want %h", vh[k].h, vh[k].v, obs(), vh[k].exp);
            end
        end
    endtask

    task automatic test_commit();
        write_entry(4, mk(100, 50, 0, 0, 1, 2), 1'b0);
        show(100, 50);
        n_checks++;
        if (obs() !== NONE) begin
            n_fail++;
            $display("FAIL commit_shadow_hidden: got %h want %h", obs(), NONE);
        end
        pulse_frame();
        show(100, 50);
        n_checks++;
        if (obs() !== e(1, 1, 2, 4)) begin
            n_fail++;
            $display("FAIL commit_after_frame: got %h want %h", obs(), e(1, 1, 2, 4));
        end
        write_entry(5, mk(150, 80, 0, 0, 0, 7), 1'b1);
        show(150, 80);
        n_checks++;
        if (obs() !== e(1, 0, 7, 5)) begin
            n_fail++;
            $display("FAIL commit_same_cycle: got %h want %h", obs(), e(1, 0, 7, 5));
        end
    endtask

    task automatic test_priority_blink();
        logic [9:0] exp;
        write_entry(3, mk(16, 16, 0, 0, 0, 4), 1'b1);
        bus.LEDs_ON_i    = '1;
        bus.LEDs_ON_i[0] = 1'b0;
        show(16, 16);
        n_checks++;
        if (obs() !== e(0, 1, 5, 0)) begin
            n_fail++;
            $display("FAIL priority_masked: got %h want %h", obs(), e(0, 1, 5, 0));
        end
        bus.LEDs_ON_i    = '1;
        bus.LEDs_ON_i[3] = 1'b0;
        show(16, 16);
        n_checks++;
        if (obs() !== e(1, 1, 5, 0)) begin
            n_fail++;
            $display("FAIL priority_lit: got %h want %h", obs(), e(1, 1, 5, 0));
        end
        bus.LEDs_ON_i = '1;
        write_entry(6, mk(200, 100, 0, 1, 1, 2), 1'b1);
        show(200, 100);
        for (int k = 0; k < 40; k++) begin
            exp = e((frame_cnt % 32) < 16, 1, 2, 6);
            n_checks++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL blink frame %0d: got %h want %h", frame_cnt, obs(), exp);
            end
            pulse_frame();
            tick();
            tick();
        end
    endtask

    task automatic test_enable();
        step_t st [16];
        logic [9:0] hh;
        hh = e(1, 1, 5, 0);
        show(16, 16);
        st = '{'{0, 300, 200, hh}, '{0, 300, 200, hh}, '{0, 300, 200, hh}, '{1, 300, 200, hh},
               '{0, 16, 16, hh}, '{0, 16, 16, hh}, '{0, 16, 16, hh}, '{1, 16, 16, NONE},
               '{0, 300, 200, NONE}, '{0, 300, 200, NONE}, '{0, 300, 200, NONE},
               '{1, 300, 200, hh}, '{0, 300, 200, hh}, '{0, 300, 200, hh},
               '{0, 300, 200, hh}, '{1, 300, 200, NONE}};
        for (int k = 0; k < 16; k++) begin
            bus.CK_EE_i = st[k].ee;
            bus.HCTRs_i = HW'(st[k].h);
            bus.VCTRs_i = VW'(st[k].v);
            tick();
            n_checks++;
            if (obs() !== st[k].exp) begin
                n_fail++;
                $display("FAIL enable step %0d: got %h want %h", k, obs(), st[k].exp);
            end
        end
        bus.CK_EE_i = 1'b0;
        write_entry(7, mk(250, 120, 0, 0, 0, 1), 1'b1);
        bus.CK_EE_i = 1'b1;
        show(250, 120);
        n_checks++;
        if (obs() !== NONE) begin
            n_fail++;
            $display("FAIL enable_frame_gated: got %h want %h", obs(), NONE);
        end
        pulse_frame();
        show(250, 120);
        n_checks++;
        if (obs() !== e(1, 0, 1, 7)) begin
            n_fail++;
            $display("FAIL enable_write_ungated: got %h want %h", obs(), e(1, 0, 1, 7));
        end
        write_entry(N, mk(450, 220, 0, 0, 1, 1), 1'b1);
        write_entry(31, mk(450, 220, 0, 0, 1, 1), 1'b1);
        show(450, 220);
        n_checks++;
        if (obs() !== NONE) begin
            n_fail++;
            $display("FAIL bad_address_write: got %h want %h", obs(), NONE);
        end
    endtask

    task automatic test_mid_reset();
        bus.CK_EE_i = 1'b0;
        bus.HCTRs_i = HW'(16);
        bus.VCTRs_i = VW'(16);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        frame_cnt = 0;
        n_checks++;
        if (obs() !== NONE) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h want %h", obs(), NONE);
        end
        bus.CK_EE_i = 1'b1;
        pulse_frame();
        show(16, 16);
        n_checks++;
        if (obs() !== NONE) begin
            n_fail++;
            $display("FAIL mid_reset_table: got %h want %h", obs(), NONE);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.CK_EE_i   = 1'b0;
        bus.FRAME_i   = 1'b0;
        bus.HCTRs_i   = '0;
        bus.VCTRs_i   = '0;
        bus.LEDs_ON_i = '0;
        bus.WR_i      = 1'b0;
        bus.WR_ADRs_i = '0;
        bus.WR_DATs_i = '0;
        test_reset();
        test_square();
        test_shapes();
        test_commit();
        test_priority_blink();
        test_enable();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
